dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised, handshaked data memory for the RISC-V core's MEM stage. It replaces the fixed 2 KB combinational-read store with a synchronous-read word array of configurable depth. It decodes RV32I load/store funct3 directly and performs byte-lane steering, sign/zero extension and misalignment detection. After reset it clears itself with an internal sequencer rather than an array-wide asynchronous reset.

## Interface
- DEPTH_WORDS, 512: number of 32-bit words; power of two, at least 4.
- ADDR_W, $clog2(DEPTH_WORDS)+2: byte-address width.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting requests; 0 = contents undefined, ready one cycle after reset.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request this cycle.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  ADDR_W  byte address.
- i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- i_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_rsp_valid  out  1  one-cycle pulse: response for the previously accepted request.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  request was misaligned or had an illegal funct3; qualified by o_rsp_valid.
- o_init_done  out  1  clear sequence finished.

## Operation
- FSM states:
  - INIT: active while CLEAR_ON_RESET=1. A counter walks words 0..DEPTH_WORDS-1, writing 0 to one word per cycle. After the last word the FSM goes to RUN.
  - RUN: o_req_ready=1. The FSM stays in RUN until reset.
- Accept: a request is accepted on a rising edge where i_req_valid && o_req_ready.
- Word index: i_req_addr[ADDR_W-1:2]. Byte offset: i_req_addr[1:0].
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value sets err.
- Misaligned: half access with offset[0]=1, or word access with offset != 0. This sets err.
- Store:
  - Byte enables are 0001, 0011 or 1111, shifted left by the offset.
  - Data is replicated into the enabled lanes.
  - Only the enabled bytes change.
  - An erroring store writes nothing.
- Load:
  - The word is read synchronously.
  - The selected byte or half is shifted down by offset*8.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - An erroring load returns 0.

## Timing
- Reset values (all outputs): o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_init_done=0. The FSM enters INIT, or RUN when CLEAR_ON_RESET=0, and the counter is 0.
- INIT duration: exactly DEPTH_WORDS cycles after reset deasserts. o_init_done and o_req_ready rise together on the next edge.
- Latency: a request accepted at edge N produces o_rsp_valid, rdata and err valid during cycle N+1 (from edge N to edge N+1). This holds for both loads and stores.
- Throughput: one request per cycle, back-to-back.
- Response backpressure: none. o_rsp_valid is a single-cycle pulse per accepted request.
- Read-after-write: a store at edge N followed by a load of the same word at edge N+1 returns the stored data. No stale data is ever returned.
- Idle output: o_rsp_rdata holds 0 when o_rsp_valid=0.
- Reset mid-operation: reset asserted during INIT or RUN immediately drops ready and valid. Any in-flight response is discarded. INIT restarts from word 0.
- Wrap-around: none, because the address width exactly spans the array.

## Structure
- Package dmem_pkg:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - enum dmem_state_e {INIT, RUN}.
  - function size_of(funct3) returning bytes.
- Sub-module dmem_lane_align (combinational): takes funct3, offset and wdata; produces byte enables, the steered write word, err, and the load extract/extend path.
- Top level holds the FSM, clear counter, array and response registers.

## Test plan
- Reset with DEPTH_WORDS=16 and CLEAR_ON_RESET=1 → o_req_ready stays 0 for 16 cycles, then 1. LW of every address returns 0 with err=0.
- SW 0x11223344 @0x8, then SB 0xAA @0x9, then LW @0x8 back-to-back → 0x1122AA44 on the cycle after the LW is accepted.
- SW 0x80FF7F01 @0x0, then LB/LBU/LH/LHU @0x1 (LH/LHU misaligned), @0x2 and @0x3:
  - LB @0x3 → 0xFFFFFF80.
  - LBU @0x3 → 0x00000080.
  - LH @0x2 → 0xFFFF80FF.
  - LHU @0x2 → 0x000080FF.
  - LH @0x1 → err=1, rdata=0.
- SW @0x6 and SH @0x3 → err=1, rdata=0, and a subsequent LW of the affected words shows them unchanged. Load with funct3=011 → err=1.
- Assert i_reset_n low for one cycle while a load is in flight and INIT is 50% complete → o_rsp_valid never pulses, and INIT restarts to the full DEPTH_WORDS count.
- 1000 random back-to-back loads and stores against a byte-array reference model → every response matches with exactly 1-cycle latency.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and helpers for the MEM-stage data memory.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    INIT,
    RUN
  } dmem_state_e;

  // Access size in bytes for a funct3; 0 marks an encoding with no defined size.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    logic [2:0] sz;
    sz = 3'd0;
    case (funct3)
      F3_B, F3_BU: sz = 3'd1;
      F3_H, F3_HU: sz = 3'd2;
      F3_W:        sz = 3'd4;
      default:     sz = 3'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extract/extend for loads, plus the
// legality/misalignment check. The store side works on the live request, the
// load side on the funct3/offset captured when the load was accepted.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic        o_err,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_offset,
  input  logic [31:0] i_rword,
  output logic [31:0] o_ldata
);

  logic [2:0]  size;
  logic        legal;
  logic        misaligned;
  logic [3:0]  base_be;
  logic [31:0] shifted;

  // Request side: decode legality, alignment, lane enables and replicated data.
  always_comb begin
    size       = size_of(i_funct3);
    legal      = 1'b0;
    misaligned = 1'b0;
    base_be    = 4'b0000;
    o_wword    = i_wdata;
    if (i_we) begin
      legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
    end else begin
      legal = (size != 3'd0);
    end
    if (size == 3'd2) misaligned = i_offset[0];
    if (size == 3'd4) misaligned = (i_offset != 2'b00);
    case (size)
      3'd1: begin
        base_be = 4'b0001;
        o_wword = {4{i_wdata[7:0]}};
      end
      3'd2: begin
        base_be = 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
      end
      3'd4:    base_be = 4'b1111;
      default: base_be = 4'b0000;
    endcase
    o_err = !legal || misaligned;
    // An erroring store must leave memory untouched, so it gets no lanes.
    o_be  = o_err ? 4'b0000 : (base_be << i_offset);
  end

  // Load side: shift the addressed lane down, then sign or zero extend.
  always_comb begin
    shifted = i_rword >> {i_ld_offset, 3'b000};
    case (i_ld_funct3)
      F3_B:    o_ldata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    o_ldata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    o_ldata = shifted;
      F3_BU:   o_ldata = {24'h0, shifted[7:0]};
      F3_HU:   o_ldata = {16'h0, shifted[15:0]};
      default: o_ldata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Handshaked, synchronous-read data memory for the MEM stage. Clears itself
// word by word after reset, then serves one load/store per cycle with a fixed
// one-cycle response.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 512,
  parameter int ADDR_W         = $clog2(DEPTH_WORDS) + 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_init_done
);

  localparam int IDX_W = ADDR_W - 2;

  dmem_state_e state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic ready_q, ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q, rsp_err_d;
  logic rsp_ld_q, rsp_ld_d;
  logic [2:0] rsp_funct3_q, rsp_funct3_d;
  logic [1:0] rsp_off_q, rsp_off_d;

  logic accept;
  logic [IDX_W-1:0] req_idx;
  logic [3:0]  req_be;
  logic [31:0] req_wword;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] rd_word;

  logic [3:0]       wr_be;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic             rd_en;

  assign accept  = i_req_valid && ready_q;
  assign req_idx = i_req_addr[ADDR_W-1:2];

  dmem_lane_align u_align (
    .i_we        (i_req_we),
    .i_funct3    (i_req_funct3),
    .i_offset    (i_req_addr[1:0]),
    .i_wdata     (i_req_wdata),
    .o_be        (req_be),
    .o_wword     (req_wword),
    .o_err       (req_err),
    .i_ld_funct3 (rsp_funct3_q),
    .i_ld_offset (rsp_off_q),
    .i_rword     (rd_word),
    .o_ldata     (ld_data)
  );

  // Next-state: clear sequencer, ready flag, write/read port selection and response capture.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wr_be        = 4'b0000;
    wr_idx       = req_idx;
    wr_data      = req_wword;
    rd_en        = 1'b0;
    rsp_valid_d  = accept;
    rsp_err_d    = accept && req_err;
    rsp_ld_d     = accept && !i_req_we && !req_err;
    rsp_funct3_d = rsp_funct3_q;
    rsp_off_d    = rsp_off_q;
    case (state_q)
      INIT: begin
        wr_be     = 4'b1111;
        wr_idx    = clr_cnt_q;
        wr_data   = 32'h0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          wr_be        = i_req_we ? req_be : 4'b0000;
          rd_en        = !i_req_we;
          rsp_funct3_d = i_req_funct3;
          rsp_off_d    = i_req_addr[1:0];
        end
      end
      default: state_d = state_q;
    endcase
    ready_d = (state_d == RUN);
  end

  // Control and response registers; reset discards any in-flight response.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= CLEAR_ON_RESET ? INIT : RUN;
      clr_cnt_q    <= '0;
      ready_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_ld_q     <= 1'b0;
      rsp_funct3_q <= 3'b000;
      rsp_off_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_ld_q     <= rsp_ld_d;
      rsp_funct3_q <= rsp_funct3_d;
      rsp_off_q    <= rsp_off_d;
    end
  end

  // One byte-wide RAM per lane so byte enables map onto independent write ports.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH_WORDS];
    logic [7:0] rd_byte_q;

    // Lane write and registered read; a store lands before a following load reads it.
    always_ff @(posedge i_clk) begin
      if (wr_be[gi]) mem_lane[wr_idx] <= wr_data[gi*8 +: 8];
      if (rd_en) rd_byte_q <= mem_lane[req_idx];
    end

    assign rd_word[gi*8 +: 8] = rd_byte_q;
  end

  assign o_req_ready = ready_q;
  assign o_init_done = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_valid_q && rsp_err_q;
  assign o_rsp_rdata = (rsp_valid_q && rsp_ld_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed and randomised checks of dmem_lsu with a 16-word array.
module tb_dmem_lsu;

  localparam int DEPTH = 16;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_f3 = 3'b000;
  logic [31:0]   req_wdata = 32'h0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [DEPTH*4];

  always #5 clk = ~clk;

  dmem_lsu #(
    .DEPTH_WORDS    (DEPTH),
    .ADDR_W         (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_funct3 (req_f3),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_init_done  (init_done)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request; its response is sampled just after the accepting edge.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [AW-1:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = a;
    req_wdata = wd;
    step();
    $display("%s we=%0d f3=%0d addr=%h wdata=%h -> valid=%0d err=%0d rdata=%h",
             tag, we, f3, a, wd, rsp_valid, rsp_err, rsp_rdata);
    check(tag, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, exp_e, exp_d});
  endtask

  task automatic idle_check(input string tag);
    req_valid = 1'b0;
    step();
    check(tag, {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
  endtask

  // Ready must stay low for DEPTH-1 edges after release and rise on edge DEPTH.
  task automatic init_wait(input string tag);
    for (int i = 0; i < DEPTH - 1; i++) begin
      step();
      check($sformatf("%s_busy%0d", tag, i), {32'h0, req_ready, init_done}, 34'h0);
    end
    step();
    check($sformatf("%s_done", tag), {32'h0, req_ready, init_done}, 34'h3);
  endtask

  // Byte-array reference: legality, alignment, store update and load extension.
  task automatic model(input logic we, input logic [2:0] f3, input int a,
                       input logic [31:0] wd, output logic [31:0] d, output logic e);
    int n;
    logic [31:0] v;
    d = 32'h0;
    e = 1'b0;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    if (n == 0) e = 1'b1;
    else if (we && f3[2]) e = 1'b1;
    else if ((a % n) != 0) e = 1'b1;
    if (e) return;
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[a + k];
      if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      d = v;
    end
  endtask

  initial begin
    logic          r_we;
    logic [2:0]    r_f3;
    int            r_a;
    logic [31:0]   r_wd;
    logic [31:0]   r_d;
    logic          r_e;

    // Reset state
    #12;
    check("reset_outputs", {rsp_valid, rsp_err, req_ready, init_done, rsp_rdata[29:0]}, 34'h0);
    check("reset_rdata", {2'b00, rsp_rdata}, 34'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_wait("init1");

    // Every word reads back zero after the clear sequence
    for (int w = 0; w < DEPTH; w++) begin
      xact($sformatf("clr_lw%0d", w), 1'b0, 3'b010, AW'(w * 4), 32'h0, 32'h0, 1'b0);
    end
    idle_check("idle0");

    // Read-after-write with a byte merge, back-to-back
    xact("sw8",  1'b1, 3'b010, 6'h08, 32'h1122_3344, 32'h0, 1'b0);
    xact("sb9",  1'b1, 3'b000, 6'h09, 32'h0000_00AA, 32'h0, 1'b0);
    xact("lw8",  1'b0, 3'b010, 6'h08, 32'h0, 32'h1122_AA44, 1'b0);

    // Extension and lane selection
    xact("sw0",   1'b1, 3'b010, 6'h00, 32'h80FF_7F01, 32'h0, 1'b0);
    xact("lb1",   1'b0, 3'b000, 6'h01, 32'h0, 32'h0000_007F, 1'b0);
    xact("lbu1",  1'b0, 3'b100, 6'h01, 32'h0, 32'h0000_007F, 1'b0);
    xact("lh1",   1'b0, 3'b001, 6'h01, 32'h0, 32'h0, 1'b1);
    xact("lhu1",  1'b0, 3'b101, 6'h01, 32'h0, 32'h0, 1'b1);
    xact("lb2",   1'b0, 3'b000, 6'h02, 32'h0, 32'hFFFF_FFFF, 1'b0);
    xact("lbu2",  1'b0, 3'b100, 6'h02, 32'h0, 32'h0000_00FF, 1'b0);
    xact("lh2",   1'b0, 3'b001, 6'h02, 32'h0, 32'hFFFF_80FF, 1'b0);
    xact("lhu2",  1'b0, 3'b101, 6'h02, 32'h0, 32'h0000_80FF, 1'b0);
    xact("lb3",   1'b0, 3'b000, 6'h03, 32'h0, 32'hFFFF_FF80, 1'b0);
    xact("lbu3",  1'b0, 3'b100, 6'h03, 32'h0, 32'h0000_0080, 1'b0);
    xact("lh3",   1'b0, 3'b001, 6'h03, 32'h0, 32'h0, 1'b1);
    xact("lw0",   1'b0, 3'b010, 6'h00, 32'h0, 32'h80FF_7F01, 1'b0);
    xact("lw2",   1'b0, 3'b010, 6'h02, 32'h0, 32'h0, 1'b1);

    // Erroring stores write nothing; illegal funct3 reports err
    xact("sw6",   1'b1, 3'b010, 6'h06, 32'hDEAD_BEEF, 32'h0, 1'b1);
    xact("sh3",   1'b1, 3'b001, 6'h03, 32'hCAFE_BABE, 32'h0, 1'b1);
    xact("sbu0",  1'b1, 3'b100, 6'h00, 32'h0000_0055, 32'h0, 1'b1);
    xact("lw4",   1'b0, 3'b010, 6'h04, 32'h0, 32'h0, 1'b0);
    xact("lw0b",  1'b0, 3'b010, 6'h00, 32'h0, 32'h80FF_7F01, 1'b0);
    xact("ld011", 1'b0, 3'b011, 6'h00, 32'h0, 32'h0, 1'b1);
    xact("ld110", 1'b0, 3'b110, 6'h08, 32'h0, 32'h0, 1'b1);
    xact("sh2",   1'b1, 3'b001, 6'h0E, 32'h0000_BEEF, 32'h0, 1'b0);
    xact("lhu_e", 1'b0, 3'b101, 6'h0E, 32'h0, 32'h0000_BEEF, 1'b0);
    xact("lw_c",  1'b0, 3'b010, 6'h0C, 32'h0, 32'hBEEF_0000, 1'b0);
    idle_check("idle1");

    // Reset while a load is in flight: the response is dropped at once
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_f3    = 3'b010;
    req_addr  = 6'h00;
    @(posedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #2;
    check("rst_inflight", {rsp_valid, rsp_err, req_ready, init_done, 30'h0}, 34'h0);
    check("rst_rdata", {2'b00, rsp_rdata}, 34'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) step();
    check("init_half_busy", {32'h0, req_ready, init_done}, 34'h0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_init", {rsp_valid, req_ready, 32'h0}, 34'h0);
    step();
    rst_n = 1'b1;
    init_wait("init2");

    // Random back-to-back traffic against the byte-array reference
    for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = int'($urandom_range(0, DEPTH * 4 - 1));
      r_wd = $urandom;
      model(r_we, r_f3, r_a, r_wd, r_d, r_e);
      xact($sformatf("rnd%0d", i), r_we, r_f3, AW'(r_a), r_wd, r_d, r_e);
    end
    idle_check("idle2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
